// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging MCU register writes/reads into the clk domain.
// Write frames commit a 32-bit word, 4-bit address and change toggle; read frames shift out a snapshot.
module spi_reg_bridge #(
  parameter logic [31:0] VERSION     = 32'h0000_0001,
  parameter int          SYNC_STAGES = 3  // must be >= 2
) (
  input  logic        clk,
  input  logic        async_reset,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [31:0] wr_reg,
  output logic [3:0]  wr_reg_addr,
  output logic        wr_reg_changed,
  input  logic [31:0] rd_loader,
  input  logic        irq_in,
  output logic        mcu_irq
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_irq_sync;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_shift, r_rd_word, r_wr_reg;
  logic [3:0]  r_addr, r_wr_addr;
  logic        r_cmd_rd, r_wr_changed, r_miso, r_miso_oe, r_armed;

  logic        w_sck_rise, w_sck_fall, w_cs_n, w_mosi;
  logic        w_enter_data, w_commit;
  logic [31:0] w_shift_next;

  function automatic logic [31:0] read_select(input logic [3:0] addr, input logic [31:0] loader);
    case (addr)
      4'd0:    return loader;
      4'd15:   return VERSION;
      default: return 32'h0;
    endcase
  endfunction

  // Index 0 takes the raw pin; edges compare the two oldest stages.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_irq_sync  <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_irq_sync  <= {r_irq_sync[SYNC_STAGES-2:0], irq_in};
    end
  end

  assign w_sck_rise   = r_sck_sync[SYNC_STAGES-2] & ~r_sck_sync[SYNC_STAGES-1];
  assign w_sck_fall   = ~r_sck_sync[SYNC_STAGES-2] & r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n       = r_cs_sync[SYNC_STAGES-2];
  assign w_mosi       = r_mosi_sync[SYNC_STAGES-2];
  assign w_shift_next = {r_shift[30:0], w_mosi};

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_enter_data = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: if (r_armed && !w_cs_n) w_state_next = CMD;
      CMD: begin
        if (w_cs_n) begin
          w_state_next = IDLE;
        end else if (w_sck_rise && r_bit_cnt == 6'd7) begin
          w_state_next = DATA;
          w_enter_data = 1'b1;
        end
      end
      DATA: begin
        // The 40th edge commits even if cs_n rises in the same cycle.
        if (w_sck_rise && r_bit_cnt == 6'd39) begin
          w_commit     = 1'b1;
          w_state_next = DONE;
        end
        if (w_cs_n) w_state_next = IDLE;
      end
      DONE: if (w_cs_n) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A frame may only start once cs_n has been seen high after reset.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_armed   <= 1'b0;
      r_miso_oe <= 1'b0;
    end else begin
      if (w_cs_n) r_armed <= 1'b1;
      r_miso_oe <= r_armed & ~w_cs_n;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cmd_rd  <= 1'b0;
      r_addr    <= '0;
      r_rd_word <= '0;
      r_miso    <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_sck_rise && (r_state == CMD || r_state == DATA)) begin
        r_shift <= w_shift_next;
        if (!w_cs_n && r_bit_cnt != 6'd40) r_bit_cnt <= r_bit_cnt + 6'd1;
      end

      if (w_enter_data) begin
        r_cmd_rd  <= w_shift_next[7];
        r_addr    <= w_shift_next[3:0];
        r_rd_word <= w_shift_next[7] ? read_select(w_shift_next[3:0], rd_loader) : 32'h0;
      end

      if (r_state != DATA) begin
        r_miso <= 1'b0;
      end else if (w_sck_fall) begin
        r_miso    <= r_cmd_rd & r_rd_word[31];
        r_rd_word <= {r_rd_word[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_wr_reg     <= '0;
      r_wr_addr    <= '0;
      r_wr_changed <= 1'b0;
    end else if (w_commit && !r_cmd_rd) begin
      r_wr_reg     <= w_shift_next;
      r_wr_addr    <= r_addr;
      r_wr_changed <= ~r_wr_changed;
    end
  end

  assign spi_miso       = r_miso;
  assign spi_miso_oe    = r_miso_oe;
  assign wr_reg         = r_wr_reg;
  assign wr_reg_addr    = r_wr_addr;
  assign wr_reg_changed = r_wr_changed;
  assign mcu_irq        = r_irq_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: writes, reads, abort, reset mid-frame and irq sync.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        spi_sck, spi_cs_n, spi_mosi, irq_in;
  logic [31:0] rd_loader;
  logic        spi_miso, spi_miso_oe, wr_reg_changed, mcu_irq;
  logic [31:0] wr_reg;
  logic [3:0]  wr_reg_addr;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .spi_sck        (spi_sck),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_miso_oe    (spi_miso_oe),
    .wr_reg         (wr_reg),
    .wr_reg_addr    (wr_reg_addr),
    .wr_reg_changed (wr_reg_changed),
    .rd_loader      (rd_loader),
    .irq_in         (irq_in),
    .mcu_irq        (mcu_irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_chg  = 1'b0;
  logic [31:0] exp_reg  = '0;
  logic [3:0]  exp_addr = '0;

  // Output monitor: counts toggles and any register change that lacks a toggle.
  int          n_toggles = 0;
  int          n_silent  = 0;
  logic        prev_chg;
  logic [31:0] prev_reg, tog_reg;
  logic [3:0]  prev_addr, tog_addr;

  always @(negedge clk) begin
    if (!async_reset) begin
      if (wr_reg_changed !== prev_chg) begin
        n_toggles++;
        tog_reg  = wr_reg;
        tog_addr = wr_reg_addr;
      end else if (wr_reg !== prev_reg || wr_reg_addr !== prev_addr) begin
        n_silent++;
      end
    end
    prev_chg  = wr_reg_changed;
    prev_reg  = wr_reg;
    prev_addr = wr_reg_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Mode 0: MOSI set while SCK low, MISO captured on the rising edge (bytes 1-4 only).
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                           input int mid_bit, input logic [31:0] mid_loader, input bit end_cs,
                           output logic [31:0] rd, output logic oe_mid);
    logic [39:0] f;
    f      = {cmd, data};
    rd     = '0;
    oe_mid = 1'b0;
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      if (i == mid_bit) rd_loader = mid_loader;
      spi_mosi = f[39-i];
      #80 spi_sck = 1'b1;
      if (i >= 8) rd = {rd[30:0], spi_miso};
      if (i == 4) oe_mid = spi_miso_oe;
      #80 spi_sck = 1'b0;
    end
    #100;
    if (end_cs) spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        oe;
    int          t0;
    t0 = n_toggles;
    spi_frame({4'h0, addr}, data, 40, -1, 32'h0, 1'b1, rd, oe);
    exp_chg  = ~exp_chg;
    exp_reg  = data;
    exp_addr = addr;
    check("wr_toggle_count", n_toggles - t0, 1);
    check("wr_changed", wr_reg_changed, exp_chg);
    check("wr_reg", wr_reg, exp_reg);
    check("wr_addr", wr_reg_addr, exp_addr);
    check("wr_reg_at_toggle", tog_reg, data);
    check("wr_addr_at_toggle", tog_addr, addr);
    check("wr_miso_quiet", rd, 32'h0);
    check("wr_oe_in_frame", oe, 1);
    check("oe_after_frame", spi_miso_oe, 0);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [31:0] loader,
                         input logic [31:0] mid_loader, input logic [31:0] exp);
    logic [31:0] rd;
    logic        oe;
    int          t0;
    t0 = n_toggles;
    rd_loader = loader;
    spi_frame(cmd, 32'h0, 40, 20, mid_loader, 1'b1, rd, oe);
    check("rd_data", rd, exp);
    check("rd_oe_in_frame", oe, 1);
    check("rd_no_toggle", n_toggles - t0, 0);
    check("rd_changed", wr_reg_changed, exp_chg);
    check("rd_wr_reg_kept", wr_reg, exp_reg);
    check("rd_miso_after", spi_miso, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        oe;
    int          t0;

    async_reset = 1'b1;
    spi_sck     = 1'b0;
    spi_cs_n    = 1'b1;
    spi_mosi    = 1'b0;
    irq_in      = 1'b0;
    rd_loader   = '0;
    #3;
    #20;
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_addr", wr_reg_addr, 0);
    check("rst_changed", wr_reg_changed, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_mcu_irq", mcu_irq, 0);
    #30 async_reset = 1'b0;
    #200;

    do_write(4'h0, 32'h0000_0521);
    do_write(4'h1, 32'h0000_0003);
    do_write(4'h0, 32'h0000_012A);

    do_read(8'h80, 32'h0000_00C4, 32'h0000_00FF, 32'h0000_00C4);
    do_read(8'h8F, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001);
    do_read(8'h87, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    // Abort after the command plus two data bytes.
    t0 = n_toggles;
    spi_frame(8'h01, 32'hAABB_0000, 24, -1, 32'h0, 1'b1, rd, oe);
    check("abort_no_toggle", n_toggles - t0, 0);
    check("abort_wr_reg", wr_reg, exp_reg);
    check("abort_wr_addr", wr_reg_addr, exp_addr);
    check("abort_changed", wr_reg_changed, exp_chg);
    do_write(4'h2, 32'hDEAD_BEEF);

    // Reset at bit 20 of a write, cs_n left low, irq_in held high.
    irq_in = 1'b1;
    spi_frame(8'h03, 32'hCAFE_F00D, 20, -1, 32'h0, 1'b0, rd, oe);
    async_reset = 1'b1;
    #1;
    check("mid_rst_wr_reg", wr_reg, 0);
    check("mid_rst_wr_addr", wr_reg_addr, 0);
    check("mid_rst_changed", wr_reg_changed, 0);
    check("mid_rst_miso", spi_miso, 0);
    check("mid_rst_miso_oe", spi_miso_oe, 0);
    check("mid_rst_mcu_irq", mcu_irq, 0);
    exp_chg  = 1'b0;
    exp_reg  = '0;
    exp_addr = '0;
    #30;
    @(negedge clk) async_reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) check("irq_before_sync", mcu_irq, 0);
    @(posedge clk);
    @(negedge clk) check("irq_after_sync", mcu_irq, 1);

    // cs_n never went high after reset, so this whole frame is ignored.
    t0 = n_toggles;
    spi_frame(8'h05, 32'h1111_2222, 40, -1, 32'h0, 1'b1, rd, oe);
    check("unarmed_no_toggle", n_toggles - t0, 0);
    check("unarmed_wr_reg", wr_reg, 0);
    check("unarmed_changed", wr_reg_changed, 0);
    check("unarmed_oe", oe, 0);
    do_write(4'hF, 32'h5A5A_0F0F);

    irq_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) check("irq_follows_low", mcu_irq, 0);
    check("no_silent_updates", n_silent, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
